// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-read-port register file with byte-enable writes, same-cycle
//             write-to-read bypass and a per-register busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    output logic [N_READ*DATA_W-1:0] rd_data,
    output logic [N_READ-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam int c_NB    = DATA_W/8;

    generate
        if (N_READ < 1 || N_READ > 4 || (DATA_W % 8) != 0) begin : g_param_check
            $error("regfile_mp: unsupported N_READ or DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0] w_mem [c_DEPTH];
    logic [c_DEPTH-1:0] w_busy;
    logic               w_wr_ok;
    logic               w_alloc_ok;
    logic [DATA_W-1:0]  w_wr_old;
    logic [DATA_W-1:0]  w_wr_merged;

    // Register 0 is non-writable/non-allocatable only when hardwired to zero.
    assign w_wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
    assign w_alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
    assign w_wr_old   = w_mem[wr_addr];

    always_comb begin
        w_wr_merged = w_wr_old;
        for (int j = 0; j < c_NB; j++) begin
            if (wr_be[j]) begin
                w_wr_merged[j*8 +: 8] = wr_data[j*8 +: 8];
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < c_DEPTH; i++) begin : g_entry
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign w_mem[i]  = '0;
                assign w_busy[i] = 1'b0;
            end else begin : g_store
                logic [DATA_W-1:0] r_data;
                logic              r_busy;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_data <= '0;
                    end else if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
                        r_data <= w_wr_merged;
                    end
                end

                // Allocation outranks a same-cycle write: a newer producer was issued.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_busy <= 1'b0;
                    end else if (w_alloc_ok && (alloc_addr == ADDR_W'(i))) begin
                        r_busy <= 1'b1;
                    end else if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
                        r_busy <= 1'b0;
                    end
                end

                assign w_mem[i]  = r_data;
                assign w_busy[i] = r_busy;
            end
        end
    endgenerate

    assign busy_vec = w_busy;

    genvar k;
    generate
        for (k = 0; k < N_READ; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit;

            assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
            assign w_hit  = (BYPASS != 0) && w_wr_ok && (wr_addr == w_addr);

            assign rd_data[k*DATA_W +: DATA_W] = w_hit ? w_wr_merged : w_mem[w_addr];
            assign rd_busy[k] = w_hit ? (alloc_en && (alloc_addr == w_addr))
                                      : w_busy[w_addr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Directed self-checking bench for regfile_mp (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;
    localparam int c_N_READ = 2;

    logic                         clk;
    logic                         reset;
    logic [c_N_READ*c_ADDR_W-1:0] rd_addr;
    logic [c_N_READ*c_DATA_W-1:0] rd_data;
    logic [c_N_READ-1:0]          rd_busy;
    logic                         wr_en;
    logic [c_ADDR_W-1:0]          wr_addr;
    logic [c_DATA_W-1:0]          wr_data;
    logic [c_DATA_W/8-1:0]        wr_be;
    logic                         alloc_en;
    logic [c_ADDR_W-1:0]          alloc_addr;
    logic [2**c_ADDR_W-1:0]       busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(
        .DATA_W  (c_DATA_W),
        .ADDR_W  (c_ADDR_W),
        .N_READ  (c_N_READ),
        .BYPASS  (1),
        .ZERO_REG(1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [c_ADDR_W-1:0] a0, input logic [c_ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [31:0] port_data(input int k);
        return rd_data[k*c_DATA_W +: c_DATA_W];
    endfunction

    task automatic check_all_clear(input string tag);
        for (int a = 0; a < 32; a++) begin
            set_rd(c_ADDR_W'(a), c_ADDR_W'(31 - a));
            #1;
            check_eq({tag, "_data0"}, 64'(port_data(0)), 64'h0);
            check_eq({tag, "_data1"}, 64'(port_data(1)), 64'h0);
            check_eq({tag, "_busy"},  64'(rd_busy),      64'h0);
        end
        check_eq({tag, "_busyvec"}, 64'(busy_vec), 64'h0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
        tick();
        reset = 1'b0;
        check_all_clear("reset");

        // Full-word write with same-cycle bypass
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        set_rd(5'd5, 5'd6);
        #1;
        check_eq("bypass_p0", 64'(port_data(0)), 64'hDEADBEEF);
        check_eq("bypass_p1_other", 64'(port_data(1)), 64'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check_eq("stored_r5", 64'(port_data(0)), 64'hDEADBEEF);

        // Byte-enable merge
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11223344; wr_be = 4'hF;
        tick();
        wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        set_rd(5'd5, 5'd7);
        #1;
        check_eq("be_bypass", 64'(port_data(1)), 64'h11BB33DD);
        check_eq("be_other_port", 64'(port_data(0)), 64'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        #1;
        check_eq("be_stored", 64'(port_data(1)), 64'h11BB33DD);

        // Register 0 hardwired to zero
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        check_eq("r0_same_p0", 64'(port_data(0)), 64'h0);
        check_eq("r0_same_p1", 64'(port_data(1)), 64'h0);
        check_eq("r0_same_busy", 64'(rd_busy), 64'h0);
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check_eq("r0_next_p0", 64'(port_data(0)), 64'h0);
        check_eq("r0_next_p1", 64'(port_data(1)), 64'h0);
        check_eq("r0_next_busyvec0", 64'(busy_vec[0]), 64'h0);

        // Scoreboard: alloc, then write, then alloc+write together
        alloc_en = 1'b1; alloc_addr = 5'd3;
        set_rd(5'd3, 5'd3);
        #1;
        check_eq("alloc_same_cycle", 64'(rd_busy), 64'h0);
        tick();
        alloc_en = 1'b0;
        #1;
        check_eq("alloc_rd_busy", 64'(rd_busy), 64'h3);
        check_eq("alloc_busyvec", 64'(busy_vec), 64'h8);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033; wr_be = 4'hF;
        #1;
        check_eq("write_clears_rd_busy", 64'(rd_busy), 64'h0);
        check_eq("write_bypass_r3", 64'(port_data(1)), 64'h33);
        check_eq("busyvec_before_edge", 64'(busy_vec), 64'h8);
        tick();
        wr_en = 1'b0;
        #1;
        check_eq("write_busyvec", 64'(busy_vec), 64'h0);
        check_eq("write_rd_busy_after", 64'(rd_busy), 64'h0);
        wr_en = 1'b1; wr_data = 32'h00000055; alloc_en = 1'b1; alloc_addr = 5'd3;
        #1;
        check_eq("alloc_write_rd_busy", 64'(rd_busy), 64'h3);
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check_eq("alloc_wins_busyvec", 64'(busy_vec), 64'h8);
        check_eq("alloc_write_data", 64'(port_data(0)), 64'h55);

        // Reset mid-operation: r3/r4/r9 busy, r4 holds data
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick();
        alloc_addr = 5'd9;
        tick();
        alloc_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00001234; wr_be = 4'hF;
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check_eq("pre_reset_busyvec", 64'(busy_vec), 64'h218);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        alloc_en = 1'b1; alloc_addr = 5'd10;
        set_rd(5'd9, 5'd4);
        #1;
        check_eq("reset_bypass_r9", 64'(port_data(0)), 64'hCAFEF00D);
        check_eq("reset_pre_r4", 64'(port_data(1)), 64'h1234);
        tick();
        reset = 1'b0; wr_en = 1'b0; alloc_en = 1'b0;
        check_all_clear("mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the pipelined CPU datapath. It replaces the fixed 32×32, two-read-port file used by the single-cycle core. It adds:
- byte-enable writes;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard, so decode can detect read-after-write hazards on registers with outstanding writes.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- N_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes/allocs ignored); 0 = register 0 is ordinary.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- rd_addr  in  N_READ*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  N_READ*DATA_W  read data; port k at [k*DATA_W +: DATA_W]; combinational.
- rd_busy  out  N_READ  1 = register at port k has an outstanding write; combinational.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; byte j updated when wr_be[j]=1.
- alloc_en  in  1  mark a register busy (issue of an instruction that will write it).
- alloc_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  2**ADDR_W  registered busy bits, for debug/stall logic.

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. With ZERO_REG=1, entry 0 is not stored; it reads 0 and its busy bit is constant 0.
- Write (wr_en=1, address writable): at the posedge, byte j of entry wr_addr takes wr_data byte j where wr_be[j]=1; other bytes keep their value. wr_be all zero leaves the data unchanged but still clears busy.
- Read port k, without bypass: rd_data_k = stored[rd_addr_k], or 0 for address 0 when ZERO_REG=1.
- Read port k, bypass case (BYPASS=1, wr_en=1, wr_addr==rd_addr_k, address writable): rd_data_k = merged value (enabled bytes from wr_data, others from the stored entry). This equals the value the entry will hold after the edge.
- Busy bits, next-state per entry, in priority order:
  - reset → 0;
  - alloc for this entry → 1 (allocation wins over a same-cycle write to the same entry);
  - write for this entry → 0;
  - otherwise hold.
- rd_busy_k:
  - With BYPASS=1 and a same-cycle write to rd_addr_k, rd_busy_k = 1 only if alloc_en=1 with alloc_addr==rd_addr_k; otherwise 0.
  - Otherwise rd_busy_k = busy[rd_addr_k].
  - A same-cycle alloc is never reflected in rd_busy in that cycle, except in the bypass case above.
- Multiple read ports may address the same entry; each port resolves independently.
- Out-of-range parameters (N_READ>4, DATA_W%8≠0) are an elaboration error.

## Timing
- Read latency 0 (combinational from rd_addr, wr_*, and stored state).
- Write latency 1: stored data is visible through a non-bypass read in the cycle after the edge.
- busy_vec updates at the posedge; no combinational path from inputs to busy_vec.
- Reset:
  - Reset high at a posedge: all entries ← 0 and all busy ← 0 at that edge. wr_en and alloc_en in the same cycle are ignored.
  - Outputs during reset remain combinational from current state: rd_data reflects pre-reset contents until the edge, and bypass still applies.
  - After the reset edge: rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reset mid-sequence discards pending busy state; the pipeline must flush alongside.
- No handshake; one write and one alloc per cycle maximum.

## Test plan
- Reset then read: assert reset 1 cycle; read all addresses on every port → rd_data=0, rd_busy=0, busy_vec=0.
- Write/read with bypass: wr_addr=5, wr_data=32'hDEADBEEF, wr_be=4'hF, rd_addr port0=5 in the same cycle → port0 shows DEADBEEF that cycle (BYPASS=1) or 0 (BYPASS=0); both modes read DEADBEEF next cycle.
- Byte enables: reg 7 = 32'h11223344; write 32'hAABBCCDD with wr_be=4'b0101 → reg 7 = 32'h11BB33DD.
- Register 0: with ZERO_REG=1, write 32'hFFFFFFFF and alloc to 0 → rd_data=0 and busy_vec[0]=0 on all ports, both same cycle and next cycle.
- Scoreboard: alloc r3 → next cycle rd_busy=1 for a port reading 3; write r3 → rd_busy=0 in the write cycle (BYPASS=1) and busy_vec[3]=0 after the edge. Alloc and write r3 in the same cycle → busy_vec[3]=1 after the edge.
- Reset mid-operation: busy r4/r9 set, reg 4 = 32'h1234; assert reset together with wr_en to r9 → after the edge all data and busy bits are 0, and r9 is not written.
